serial_frame_rx: RTL and testbench

Serial frame receiver sitting directly downstream of the single-bit registered `buffer` stage. It consumes the buffered line `out` as its `in`, one bit per clock. It detects a start bit, shifts in a fixed-width data word LSB first, checks optional parity and the stop bit, then presents the word with a one-cycle valid pulse. It also keeps a wrapping count of good frames for debug visibility.

---
 rtl/serial_frame_rx.sv | 140 ++++++++++++++
 tb/tb_serial_frame_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Serial frame receiver fed by a single-bit registered line. A frame is a
//   start bit (0), DATA_W data bits LSB first, an optional parity bit and a
//   stop bit (1), one bit per clock. A good frame updates data_out and pulses
//   valid (with parity_err if the parity check fails). A bad stop bit pulses
//   frame_err and the receiver then waits for the line to return high before
//   it looks for a new start bit.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in         in   serial line, idle high
//   data_out   out  last good word, held between frames
//   valid      out  one-cycle pulse when data_out is updated
//   parity_err out  one-cycle pulse alongside valid on a parity mismatch
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   busy       out  high whenever the receiver is not idle
//   frame_cnt  out  wrapping count of frames with a good stop bit
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d;       // parity verdict held until STOP
    logic              valid_q, valid_d;
    logic              perr_out_q, perr_out_d;
    logic              ferr_q, ferr_d;
    logic [7:0]        fcnt_q, fcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        perr_d     = perr_q;
        valid_d    = 1'b0;
        perr_out_d = 1'b0;
        ferr_d     = 1'b0;
        fcnt_d     = fcnt_q;

        case (state_q)
            IDLE: begin
                if (!in) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;   // stays clear when there is no parity bit
                end
            end
            DATA: begin
                shift_d[bit_cnt_q] = in;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            PARITY: begin
                perr_d  = ((^shift_q) ^ in) != ODD;
                state_d = STOP;
            end
            STOP: begin
                if (in) begin
                    data_d     = shift_q;
                    valid_d    = 1'b1;
                    perr_out_d = perr_q;
                    fcnt_d     = fcnt_q + 8'd1;
                    state_d    = IDLE;
                end else begin
                    // Line is stuck low: flag it and refuse to treat the
                    // following zeros as start bits.
                    ferr_d  = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);
    assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

    typedef struct {
        logic [15:0] data;
        bit          perr;
        bit          ferr;
        logic [7:0]  cnt;
        int          cyc;
    } exp_t;

    logic clk, rst_n;
    logic in_a, in_b;

    // DUT a: defaults (8 data bits, even parity)
    logic [7:0] data_a;
    logic       va, pea, fea, busy_a;
    logic [7:0] cnt_a_o;
    // DUT b: 5 data bits, no parity
    logic [4:0] data_b;
    logic       vb, peb, feb, busy_b;
    logic [7:0] cnt_b_o;

    serial_frame_rx u_a (
        .clk(clk), .rst_n(rst_n), .in(in_a),
        .data_out(data_a), .valid(va), .parity_err(pea), .frame_err(fea),
        .busy(busy_a), .frame_cnt(cnt_a_o)
    );

    serial_frame_rx #(.DATA_W(5), .PARITY_EN(0), .PARITY_ODD(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in(in_b),
        .data_out(data_b), .valid(vb), .parity_err(peb), .frame_err(feb),
        .busy(busy_b), .frame_cnt(cnt_b_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t qa[$];
    exp_t qb[$];
    logic [7:0]  mcnt_a, mcnt_b;     // model frame counters
    logic [15:0] last_a, last_b;     // model of data_out

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_line(input int dut, input logic b);
        @(negedge clk);
        if (dut == 0) in_a = b; else in_b = b;
    endtask

    // Drives one full frame and queues the response the receiver owes us.
    task automatic send_frame(input int dut, input logic [15:0] d,
                              input bit bad_par, input bit bad_stop);
        int   w, l;
        bit   par_en;
        logic p;
        exp_t e;
        w      = (dut == 0) ? 8 : 5;
        par_en = (dut == 0);
        l      = 1 + w + (par_en ? 1 : 0) + 1;
        p      = 1'b0;
        for (int i = 0; i < w; i++) p = p ^ d[i];
        p = p ^ bad_par;                      // even parity unless corrupted

        set_line(dut, 1'b0);                  // start bit
        e.cyc = cyc + l;                      // valid seen after edge k+L-1
        e.ferr = bad_stop;
        if (dut == 0) begin
            e.perr = bad_par && !bad_stop;
            if (!bad_stop) begin mcnt_a = mcnt_a + 8'd1; last_a = d & 16'h00FF; end
            e.data = last_a;
            e.cnt  = mcnt_a;
            qa.push_back(e);
        end else begin
            e.perr = 1'b0;
            if (!bad_stop) begin mcnt_b = mcnt_b + 8'd1; last_b = d & 16'h001F; end
            e.data = last_b;
            e.cnt  = mcnt_b;
            qb.push_back(e);
        end

        for (int i = 0; i < w; i++) begin
            set_line(dut, d[i]);
            if (i == 1) chk(dut == 0 ? "a_busy_mid" : "b_busy_mid",
                            {31'd0, (dut == 0) ? busy_a : busy_b}, 32'd1);
        end
        if (par_en) set_line(dut, p);
        set_line(dut, !bad_stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_a = 1'b1;
            in_b = 1'b1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_a"}, {24'd0, data_a}, 32'd0);
        chk({tag, "_valid_a"}, {31'd0, va}, 32'd0);
        chk({tag, "_perr_a"}, {31'd0, pea}, 32'd0);
        chk({tag, "_ferr_a"}, {31'd0, fea}, 32'd0);
        chk({tag, "_busy_a"}, {31'd0, busy_a}, 32'd0);
        chk({tag, "_cnt_a"}, {24'd0, cnt_a_o}, 32'd0);
        chk({tag, "_data_b"}, {27'd0, data_b}, 32'd0);
        chk({tag, "_cnt_b"}, {24'd0, cnt_b_o}, 32'd0);
    endtask

    // Monitors: every valid or frame_err pulse must match the oldest
    // outstanding expectation; a pulse with nothing pending is an error.
    exp_t ea, eb;
    always @(negedge clk) begin
        if (rst_n && (va || fea)) begin
            if (qa.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL a_unexpected: valid=%0b frame_err=%0b data=%0h, expected no pulse (cycle %0d)",
                         va, fea, data_a, cyc);
            end else begin
                ea = qa.pop_front();
                chk("a_valid", {31'd0, va}, {31'd0, !ea.ferr});
                chk("a_frame_err", {31'd0, fea}, {31'd0, ea.ferr});
                chk("a_parity_err", {31'd0, pea}, {31'd0, ea.perr});
                chk("a_data", {24'd0, data_a}, {16'd0, ea.data});
                chk("a_frame_cnt", {24'd0, cnt_a_o}, {24'd0, ea.cnt});
                chk("a_cycle", cyc, ea.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (vb || feb)) begin
            if (qb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL b_unexpected: valid=%0b frame_err=%0b data=%0h, expected no pulse (cycle %0d)",
                         vb, feb, data_b, cyc);
            end else begin
                eb = qb.pop_front();
                chk("b_valid", {31'd0, vb}, {31'd0, !eb.ferr});
                chk("b_frame_err", {31'd0, feb}, {31'd0, eb.ferr});
                chk("b_parity_err", {31'd0, peb}, 32'd0);
                chk("b_data", {27'd0, data_b}, {16'd0, eb.data});
                chk("b_frame_cnt", {24'd0, cnt_b_o}, {24'd0, eb.cnt});
                chk("b_cycle", cyc, eb.cyc);
            end
        end
    end

    initial begin
        mcnt_a = 8'd0; mcnt_b = 8'd0;
        last_a = 16'd0; last_b = 16'd0;
        in_a = 1'b1; in_b = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        idle(2);

        // Good frame, then the same frame with the parity bit flipped.
        send_frame(0, 16'h00A5, 1'b0, 1'b0);
        idle(3);
        send_frame(0, 16'h00A5, 1'b1, 1'b0);
        idle(3);

        // Bad stop bit, line held low, must not restart on the zeros.
        send_frame(0, 16'h003C, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            set_line(0, 1'b0);
            if (i == 2) chk("a_busy_wait_idle", {31'd0, busy_a}, 32'd1);
        end
        set_line(0, 1'b1);
        send_frame(0, 16'h005A, 1'b0, 1'b0);
        idle(3);

        // Back-to-back frames with no idle bit between them.
        send_frame(0, 16'h0000, 1'b0, 1'b0);
        send_frame(0, 16'h00FF, 1'b0, 1'b0);
        send_frame(0, 16'h0081, 1'b0, 1'b0);
        idle(4);

        // Reset partway through a frame: start plus four data bits of 0x5A.
        set_line(0, 1'b0);
        set_line(0, 1'b0);
        set_line(0, 1'b1);
        set_line(0, 1'b0);
        set_line(0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        in_a  = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        mcnt_a = 8'd0; mcnt_b = 8'd0;
        last_a = 16'd0; last_b = 16'd0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        send_frame(0, 16'h00A5, 1'b0, 1'b0);
        idle(2);

        // Fill the counter to 255, then one more frame wraps it to 0
        // (the wrapping frame also carries a parity error).
        for (int i = 0; i < 254; i++) send_frame(0, 16'(i * 7 + 3), 1'b0, 1'b0);
        idle(2);
        chk("a_cnt_pre_wrap", {24'd0, cnt_a_o}, 32'd255);
        send_frame(0, 16'h00C3, 1'b1, 1'b0);
        idle(3);
        chk("a_cnt_wrapped", {24'd0, cnt_a_o}, 32'd0);

        // Narrow, parity-free instance: 7-cycle frames, 5-bit data.
        send_frame(1, 16'h0015, 1'b0, 1'b0);
        idle(2);
        send_frame(1, 16'h001F, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 254; i++) send_frame(1, 16'(i), 1'b0, 1'b0);
        idle(2);
        chk("b_cnt_pre_wrap", {24'd0, cnt_b_o}, 32'd255);
        send_frame(1, 16'h000A, 1'b0, 1'b0);
        idle(3);
        chk("b_cnt_wrapped", {24'd0, cnt_b_o}, 32'd0);
        chk("b_data_final", {27'd0, data_b}, 32'h0A);

        // Every queued response must have been seen within a bounded wait.
        for (int i = 0; i < 40 && (qa.size() + qb.size()) != 0; i++) @(negedge clk);
        chk("drain_pending", qa.size() + qb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
